// File: rtl/hex_display_seq_pkg.sv
// rtl/hex_display_seq_pkg.sv - segment encodings, FSM states and helpers shared by hex_display_seq
package hex_display_seq_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low segments, bit0 = a .. bit6 = g
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STORE = 2'd2
  } state_e;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_seg.sv
// rtl/bcd_seg.sv - combinational BCD digit to active-low seven-segment decoder; codes 10-15 blank
module bcd_seg
  import hex_display_seq_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (code <= 4'd9) seg = SEG_DIGIT[code];
  end

endmodule

// File: rtl/hex_display_seq.sv
// rtl/hex_display_seq.sv - time-shared double-dabble binary to seven-segment display driver
// Optional leading-zero blanking enabled by defining HEX_DISPLAY_LZB_EN.
module hex_display_seq
  import hex_display_seq_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int IN_WIDTH = 6,
  parameter int DIGITS   = 2,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*IN_WIDTH-1:0] in,
  output logic [CHANNELS*DIGITS*7-1:0] hex,
  output logic [CHANNELS-1:0]          ovf,
  output logic                         upd,
  output logic [CH_W-1:0]              upd_ch
);

  localparam int SH_W  = 4*DIGITS + IN_WIDTH;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam longint unsigned LIMIT = pow10(DIGITS);

  state_e                       state_q, state_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [SH_W-1:0]              sh_q, sh_d;
  logic [IN_WIDTH-1:0]          val_q, val_d;
  logic [CHANNELS*DIGITS*7-1:0] hex_q, hex_d;
  logic [CHANNELS-1:0]          ovf_q, ovf_d;
  logic                         upd_q, upd_d;
  logic [CH_W-1:0]              upd_ch_q, upd_ch_d;

  logic [6:0] seg_raw [DIGITS];

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    bcd_seg u_seg (
      .code (sh_q[IN_WIDTH + 4*d +: 4]),
      .seg  (seg_raw[d])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      ch_q     <= '0;
      cnt_q    <= '0;
      sh_q     <= '0;
      val_q    <= '0;
      hex_q    <= '1;
      ovf_q    <= '0;
      upd_q    <= 1'b0;
      upd_ch_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      val_q    <= val_d;
      hex_q    <= hex_d;
      ovf_q    <= ovf_d;
      upd_q    <= upd_d;
      upd_ch_q <= upd_ch_d;
    end
  end

  always_comb begin
    logic [SH_W-1:0] adj;
    logic [6:0]      seg;
    logic            over;
`ifdef HEX_DISPLAY_LZB_EN
    logic            lead;
    lead     = 1'b1;
`endif
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    val_d    = val_q;
    hex_d    = hex_q;
    ovf_d    = ovf_q;
    upd_d    = 1'b0;
    upd_ch_d = upd_ch_q;
    adj      = sh_q;
    seg      = SEG_BLANK;
    over     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        val_d   = in[int'(ch_q)*IN_WIDTH +: IN_WIDTH];
        sh_d    = {{(4*DIGITS){1'b0}}, val_d};
        cnt_d   = CNT_W'(IN_WIDTH);
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        for (int d = 0; d < DIGITS; d++) begin
          if (adj[IN_WIDTH + 4*d +: 4] >= 4'd5)
            adj[IN_WIDTH + 4*d +: 4] = adj[IN_WIDTH + 4*d +: 4] + 4'd3;
        end
        sh_d  = {adj[SH_W-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_STORE;
      end
      ST_STORE: begin
        // Overflow is judged on the sampled value; the BCD field is truncated.
        over = (64'(val_q) >= LIMIT);
        for (int d = DIGITS - 1; d >= 0; d--) begin
          seg = seg_raw[d];
`ifdef HEX_DISPLAY_LZB_EN
          lead = lead && (sh_q[IN_WIDTH + 4*d +: 4] == 4'd0);
          if (lead && d != 0) seg = SEG_BLANK;
`endif
          if (over) seg = SEG_DASH;
          hex_d[(int'(ch_q)*DIGITS + d)*7 +: 7] = seg;
        end
        ovf_d[ch_q] = over;
        upd_d       = 1'b1;
        upd_ch_d    = ch_q;
        ch_d        = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
        state_d     = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  assign hex    = hex_q;
  assign ovf    = ovf_q;
  assign upd    = upd_q;
  assign upd_ch = upd_ch_q;

endmodule

// File: tb/tb_hex_display_seq.sv
// tb/tb_hex_display_seq.sv - self-checking bench for hex_display_seq (two-channel and one-channel builds)
module tb_hex_display_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] in_a;
  logic [27:0] hex_a;
  logic [1:0]  ovf_a;
  logic        upd_a;
  logic [0:0]  upd_ch_a;
  logic [7:0]  in_b;
  logic [13:0] hex_b;
  logic [0:0]  ovf_b;
  logic        upd_b;
  logic [0:0]  upd_ch_b;

  int n_asserts = 0;
  int n_fails   = 0;

  typedef struct {
    int ch;
    int val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  hex_display_seq #(.CHANNELS(2), .IN_WIDTH(6), .DIGITS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .hex(hex_a),
    .ovf(ovf_a), .upd(upd_a), .upd_ch(upd_ch_a)
  );

  hex_display_seq #(.CHANNELS(1), .IN_WIDTH(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .hex(hex_b),
    .ovf(ovf_b), .upd(upd_b), .upd_ch(upd_ch_b)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [13:0] model(input int v);
    logic [6:0] hi, lo;
    if (v >= 100) return {7'h3F, 7'h3F};
    lo = seg_of(v % 10);
    hi = seg_of(v / 10);
`ifdef HEX_DISPLAY_LZB_EN
    if (v < 10) hi = 7'h7F;
`endif
    return {hi, lo};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int val);
    exp_t e;
    e.ch  = ch;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic wait_upd_a(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < 40) begin
      tick();
      cyc++;
      ok = upd_a;
    end
  endtask

  task automatic wait_upd_b(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < 40) begin
      tick();
      cyc++;
      ok = upd_b;
    end
  endtask

  task automatic expect_a(input string tag, output int cyc);
    bit   ok;
    exp_t e;
    wait_upd_a(cyc, ok);
    check({tag, "_seen"}, 32'(ok), 32'd1);
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_ch"},  32'(upd_ch_a), 32'(e.ch));
      check({tag, "_hex"}, 32'(hex_a[e.ch*14 +: 14]), 32'(model(e.val)));
      check({tag, "_ovf"}, 32'(ovf_a[e.ch]), 32'(e.val >= 100));
    end
  endtask

  task automatic expect_b(input string tag, input int val, input int gap);
    int cyc;
    bit ok;
    wait_upd_b(cyc, ok);
    check({tag, "_seen"}, 32'(ok), 32'd1);
    check({tag, "_gap"},  32'(cyc), 32'(gap));
    check({tag, "_ch"},   32'(upd_ch_b), 32'd0);
    check({tag, "_hex"},  32'(hex_b), 32'(model(val)));
    check({tag, "_ovf"},  32'(ovf_b), 32'(val >= 100));
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    in_a  = {6'd63, 6'd5};
    in_b  = 8'd0;
    repeat (3) tick();
    check("rst_hex_a",  32'(hex_a), 32'h0FFF_FFFF);
    check("rst_ovf_a",  32'(ovf_a), 32'd0);
    check("rst_upd_a",  32'(upd_a), 32'd0);
    check("rst_updch",  32'(upd_ch_a), 32'd0);
    check("rst_hex_b",  32'(hex_b), 32'h3FFF);

    rst_n = 1'b1;
    push(0, 5);
    push(1, 63);
    expect_a("first", cyc);
    check("first_cycle", 32'(cyc), 32'd8);
    expect_a("second", cyc);
    check("second_gap", 32'(cyc), 32'd8);

    in_a = {6'd42, 6'd9};
    push(0, 9);
    push(1, 42);
    expect_a("conv0", cyc);
    expect_a("conv1", cyc);

    in_a[5:0] = 6'd12;
    push(0, 12);
    push(1, 42);
    repeat (3) tick();
    in_a[5:0] = 6'd34;
    push(0, 34);
    expect_a("mid_old", cyc);
    expect_a("mid_ch1", cyc);
    expect_a("mid_new", cyc);

    in_a = {6'd63, 6'd0};
    push(1, 63);
    push(0, 0);
    expect_a("max63", cyc);
    expect_a("zero", cyc);

    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_hex", 32'(hex_a), 32'h0FFF_FFFF);
    check("midrst_ovf", 32'(ovf_a), 32'd0);
    check("midrst_upd", 32'(upd_a), 32'd0);
    in_a = {6'd17, 6'd50};
    in_b = 8'd100;
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    push(0, 50);
    push(1, 17);
    push(0, 50);
    expect_a("restart0", cyc);
    check("restart_cycle", 32'(cyc), 32'd8);
    expect_a("restart1", cyc);
    expect_a("restart2", cyc);

    expect_b("ovf100", 100, 6);
    in_b = 8'd99;
    expect_b("fit99", 99, 10);
    in_b = 8'd0;
    expect_b("b_zero", 0, 10);
    in_b = 8'd255;
    expect_b("ovf255", 255, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/hex_display_seq.md
Name: hex_display_seq

Overview:
- Parametrised successor of the pc/sp seven-segment display path.
- Replaces the fixed combinational binary-to-BCD stage with a sequential, time-shared double-dabble converter. The converter serves CHANNELS independent binary values, each shown on DIGITS seven-segment digits.
- Sits between the cpu status outputs (pc, sp, out, ...) and the board hex pins; runs on the fast board clock.

Parameters:
- CHANNELS, 2, number of independent values displayed.
- IN_WIDTH, 6, width in bits of each input value.
- DIGITS, 2, decimal digits per channel; must satisfy 10^DIGITS > 1.
- Derived localparam SH_W = 4*DIGITS + IN_WIDTH, the width of the shift register.

Ports:
- clk  input  1  board clock.
- rst_n  input  1  asynchronous active-low reset.
- in  input  CHANNELS*IN_WIDTH  packed values; channel c occupies bits [c*IN_WIDTH +: IN_WIDTH].
- hex  output  CHANNELS*DIGITS*7  segments, active-low, bit0=a..bit6=g. Channel c, digit d (d=0 is ones) occupies bits [(c*DIGITS+d)*7 +: 7].
- ovf  output  CHANNELS  per-channel flag: value does not fit in DIGITS digits.
- upd  output  1  one-cycle pulse when a channel's display registers are written.
- upd_ch  output  clog2(CHANNELS) (min 1)  channel index written; valid with upd.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - hex = all 1s (blank); ovf = 0; upd = 0; upd_ch = 0.
  - FSM goes to LOAD; channel pointer = 0.
- FSM states are LOAD, SHIFT and STORE, looping forever with no idle state.
- LOAD (1 cycle):
  - Sample in[ch] into the low IN_WIDTH bits of the shift register; clear the upper 4*DIGITS bits.
  - Set bit counter = IN_WIDTH. Go to SHIFT.
- SHIFT (IN_WIDTH cycles):
  - Each cycle, first add 3 to every BCD nibble that is >= 5, then shift the whole register left by 1.
  - Decrement the counter; at the last shift go to STORE.
- STORE (1 cycle):
  - Decode each BCD nibble to segments and write them into hex for channel ch.
  - Set ovf[ch] = (sampled value >= 10^DIGITS).
  - Pulse upd = 1 with upd_ch = ch.
  - ch wraps to 0 after CHANNELS-1. Go to LOAD.
- Latency:
  - Per channel: IN_WIDTH+2 cycles from LOAD to visible hex.
  - Full refresh period: CHANNELS*(IN_WIDTH+2) cycles.
- Sampling:
  - in is sampled only in LOAD. Changes during SHIFT or STORE appear on the next visit to that channel.
  - No glitch on hex: registers change only in STORE.
- Overflow:
  - The comparison is made on the sampled value, not on the truncated BCD result.
  - When ovf[ch] = 1, every digit of that channel shows dash 7'b0111111.
  - When the value fits, digits show 0-9 normally.
- Inputs are treated as unsigned; no sign handling.
- CHANNELS=1: upd_ch is constant 0 and the pointer never advances.
- Reset asserted mid-SHIFT: the conversion is aborted, all displays blank, and the FSM restarts at channel 0 after release.
- Outputs hold their value between STOREs. Other channels are untouched during any STORE.

Optional Feature:
- Macro: HEX_DISPLAY_LZB_EN.
- Defined: leading-zero blanking. Any digit above the most significant non-zero digit is blank (7'h7F). The ones digit is always shown, so value 0 shows "0".
  - Example: 7 with DIGITS=2 shows blank/"7".
  - Overflow dash display takes precedence over blanking.
- Undefined: all DIGITS are shown with leading zeros (7 shows "07").

Decomposition:
- Shared header (included .vh):
  - segment constants SEG_BLANK=7'h7F, SEG_DASH=7'h3F, and the digit 0-9 encoding table;
  - FSM state encodings ST_LOAD, ST_SHIFT, ST_STORE.
- One natural sub-module, bcd_seg, a combinational 4-bit digit to 7-segment decoder. It uses the header table and outputs blank for codes 10-15. It is instantiated DIGITS times and reused from the STORE datapath.
- FSM, shift register and per-channel hex/ovf registers stay in hex_display_seq.

Test Plan:
- Reset: hold rst_n=0 with in={6'd63,6'd5} → hex all 1s, ovf=0, upd=0. After release, first upd at cycle 8 with upd_ch=0; second upd at cycle 16 with upd_ch=1.
- Conversion (defaults): in={6'd42,6'd9} → ch1 shows "42"; ch0 shows "09", or blank/"9" with LZB.
- Overflow: IN_WIDTH=8, DIGITS=2, in=8'd100 → ovf=1 and both digits 7'h3F. Then in=8'd99 → ovf clears on the next update and "99" is shown.
- Mid-conversion change: change ch0 from 12 to 34 on the third SHIFT cycle → the current STORE shows "12"; the next ch0 STORE shows "34".
- Reset mid-op: assert rst_n low during SHIFT of ch1 → immediate blank. After release, the FSM restarts at ch0 and upd_ch sequence is 0,1,0.
- Boundaries: value 0 → "00", or blank/"0" with LZB. Value 63 → "63". CHANNELS=1 → upd every IN_WIDTH+2 cycles, always with upd_ch=0.
